// File: rtl/bloco_operativo.sv
// Operative block: X/H/S registers, operand muxes, adder and a shift-add multiplier FSM.
// Optional sticky overflow flag `ovf` when BO_OVERFLOW_CHK_EN is defined.
module bloco_operativo #(
    parameter int W  = 8,
    parameter int C0 = 1,
    parameter int C1 = 2,
    parameter int C2 = 3
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [W-1:0] x_in,
    input  logic         lx,
    input  logic [1:0]   m0,
    input  logic [1:0]   m1,
    input  logic [1:0]   m2,
    input  logic         h,
    input  logic         lh,
    input  logic         ls,
    input  logic         done,
    output logic         pronto,
    output logic [W-1:0] s_out,
    output logic         valid
`ifdef BO_OVERFLOW_CHK_EN
    ,
    output logic         ovf
`endif
);

`ifdef BO_OVERFLOW_CHK_EN
    // Keep the full-width product so bits above W can flag overflow.
    localparam int PW = 2 * W;
`else
    localparam int PW = W;
`endif
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] C0_W = W'(C0);
    localparam logic [W-1:0] C1_W = W'(C1);
    localparam logic [W-1:0] C2_W = W'(C2);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mult_state_t;

    mult_state_t     state_q;
    logic [PW-1:0]   a_q;
    logic [W-1:0]    b_q;
    logic [PW-1:0]   prod_q;
    logic [CW-1:0]   cnt_q;
    logic            pronto_q;

    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    h_q, h_d;
    logic [W-1:0]    s_q, s_d;
    logic            valid_q, valid_d;

    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    alu_sum;
    logic [W-1:0]    alu_res;
    logic            h_load;

    always_comb begin
        op_a = '0;
        case (m0)
            2'b00:   op_a = '0;
            2'b01:   op_a = x_q;
            2'b10:   op_a = C1_W;
            default: op_a = C2_W;
        endcase
        op_b = '0;
        case (m1)
            2'b00:   op_b = h_q;
            2'b01:   op_b = x_q;
            2'b10:   op_b = C0_W;
            default: op_b = '0;
        endcase
    end

`ifdef BO_OVERFLOW_CHK_EN
    logic add_carry;
    assign {add_carry, alu_sum} = {1'b0, op_a} + {1'b0, op_b};
`else
    assign alu_sum = op_a + op_b;
`endif

    assign alu_res = h ? prod_q[W-1:0] : alu_sum;

    // Loading H from a multiply that has not finished would capture garbage.
    assign h_load = lh && !((m2 == 2'b11) && h && !pronto_q);

    always_comb begin
        x_d = x_q;
        if (lx) x_d = x_in;
        h_d = h_q;
        if (h_load) begin
            case (m2)
                2'b00:   h_d = '0;
                2'b01:   h_d = x_q;
                2'b10:   h_d = C0_W;
                default: h_d = alu_res;
            endcase
        end
        s_d = ls ? h_q : s_q;
        valid_d = done;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            x_q     <= '0;
            h_q     <= '0;
            s_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            h_q     <= h_d;
            s_q     <= s_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            pronto_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pronto_q <= 1'b0;
                    if (h) begin
                        a_q     <= PW'(op_a);
                        b_q     <= op_b;
                        prod_q  <= '0;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!h) begin
                        prod_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        if (b_q[0]) prod_q <= prod_q + a_q;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(W - 1)) begin
                            state_q  <= DONE;
                            pronto_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!h) begin
                        state_q  <= IDLE;
                        pronto_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    pronto_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BO_OVERFLOW_CHK_EN
    logic ovf_q, ovf_d;
    logic alu_wide;

    assign alu_wide = h ? (|prod_q[PW-1:W]) : add_carry;

    always_comb begin
        ovf_d = ovf_q;
        if (h_load && (m2 == 2'b11) && alu_wide) ovf_d = 1'b1;
        if (lx) ovf_d = 1'b0;
    end

    always_ff @(posedge ck) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    assign pronto = pronto_q;
    assign s_out  = s_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_bloco_operativo.sv
// Self-checking bench for bloco_operativo: behavioural model of X/H/S plus a scoreboard on s_out.
module tb_bloco_operativo;
    localparam int W  = 8;
    localparam int C0 = 1;
    localparam int C1 = 2;
    localparam int C2 = 3;
    localparam int MASK = (1 << W) - 1;

    logic         ck = 1'b0;
    logic         rst;
    logic [W-1:0] x_in;
    logic         lx;
    logic [1:0]   m0, m1, m2;
    logic         h, lh, ls, done;
    logic         pronto;
    logic [W-1:0] s_out;
    logic         valid;
`ifdef BO_OVERFLOW_CHK_EN
    logic         ovf;
`endif

    always #5 ck = ~ck;

    bloco_operativo #(.W(W), .C0(C0), .C1(C1), .C2(C2)) dut (
        .ck(ck), .rst(rst), .x_in(x_in), .lx(lx),
        .m0(m0), .m1(m1), .m2(m2), .h(h), .lh(lh), .ls(ls), .done(done),
        .pronto(pronto), .s_out(s_out), .valid(valid)
`ifdef BO_OVERFLOW_CHK_EN
        , .ovf(ovf)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] sb_q[$];
    int x_m, h_m, s_m;
    bit ovf_m;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic applyStimulus(input bit lx_i, input int xv, input bit [1:0] m0_i,
                                 input bit [1:0] m1_i, input bit [1:0] m2_i, input bit h_i,
                                 input bit lh_i, input bit ls_i, input bit done_i);
        lx = lx_i; x_in = W'(xv); m0 = m0_i; m1 = m1_i; m2 = m2_i;
        h = h_i; lh = lh_i; ls = ls_i; done = done_i;
        tick();
    endtask

    function automatic int opa(input bit [1:0] sel);
        case (sel)
            2'b00:   return 0;
            2'b01:   return x_m;
            2'b10:   return C1;
            default: return C2;
        endcase
    endfunction

    function automatic int opb(input bit [1:0] sel);
        case (sel)
            2'b00:   return h_m;
            2'b01:   return x_m;
            2'b10:   return C0;
            default: return 0;
        endcase
    endfunction

    task automatic load_x(input int v);
        applyStimulus(1, v, 0, 0, 0, 0, 0, 0, 0);
        x_m = v;
        ovf_m = 0;
    endtask

    task automatic store_s(input string tag);
        s_m = h_m;
        sb_q.push_back(W'(s_m));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput(tag, s_out, sb_q.pop_front());
    endtask

    task automatic add_op(input bit [1:0] a_sel, input bit [1:0] b_sel);
        int sum;
        sum = opa(a_sel) + opb(b_sel);
        applyStimulus(0, 0, a_sel, b_sel, 3, 0, 1, 0, 0);
        if (sum > MASK) ovf_m = 1;
        h_m = sum & MASK;
    endtask

    // Operand selects are scrambled while busy: only the values captured at start may count.
    task automatic mul_op(input string tag, input bit [1:0] a_sel, input bit [1:0] b_sel, input bit probe);
        int prod;
        int n;
        prod = opa(a_sel) * opb(b_sel);
        applyStimulus(0, 0, a_sel, b_sel, 3, 1, 0, 0, 0);
        checkOutput({tag, "_start"}, pronto, 0);
        n = 0;
        while (pronto !== 1'b1 && n < 3 * W) begin
            m0 = 2'($urandom);
            m1 = 2'($urandom);
            lh = probe && (n == 0);
            ls = probe && (n == 1);
            tick();
            n++;
            if (probe && n == 2) begin
                s_m = h_m;
                checkOutput({tag, "_early_lh"}, s_out, h_m);
            end
        end
        checkOutput({tag, "_latency"}, n, W);
        applyStimulus(0, 0, 0, 0, 3, 1, 1, 0, 0);
        h_m = prod & MASK;
        if (prod > MASK) ovf_m = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput({tag, "_pronto_drop"}, pronto, 0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        x_m = 0; h_m = 0; s_m = 0; ovf_m = 0;
        checkOutput("rst_s_out", s_out, 0);
        checkOutput("rst_pronto", pronto, 0);
        checkOutput("rst_valid", valid, 0);
`ifdef BO_OVERFLOW_CHK_EN
        checkOutput("rst_ovf", ovf, 0);
`endif

        load_x(4);
        add_op(2'b01, 2'b10);
        store_s("add_x_c0");

        load_x(5);
        mul_op("mul_5x5", 2'b01, 2'b01, 1);
        store_s("mul_5x5_s");

        load_x(20);
        mul_op("mul_trunc", 2'b01, 2'b01, 0);
        store_s("mul_trunc_s");
`ifdef BO_OVERFLOW_CHK_EN
        checkOutput("ovf_set", ovf, 32'(ovf_m));
        load_x(3);
        checkOutput("ovf_clear", ovf, 32'(ovf_m));
`endif

        load_x(6);
        applyStimulus(0, 0, 2'b01, 2'b01, 0, 1, 0, 0, 0);
        repeat (3) tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < W + 2; i++) begin
            if (pronto === 1'b1) seen = 1;
            tick();
        end
        checkOutput("abort_no_pronto", 32'(seen), 0);
        mul_op("mul_restart", 2'b10, 2'b01, 0);
        store_s("mul_restart_s");

        load_x(7);
        add_op(2'b01, 2'b11);
        store_s("pre_rst_s");
        applyStimulus(0, 0, 2'b01, 2'b01, 0, 1, 0, 0, 1);
        rst = 1'b1;
        applyStimulus(0, 0, 2'b01, 2'b01, 0, 1, 0, 0, 1);
        checkOutput("midrst_s_out", s_out, 0);
        checkOutput("midrst_pronto", pronto, 0);
        checkOutput("midrst_valid", valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        x_m = 0; h_m = 0; s_m = 0; ovf_m = 0;
        add_op(2'b01, 2'b11);
        store_s("post_rst_x");

        // Controller pass reaching 34 using only operand pairs the muxes offer.
        load_x(3);
        add_op(2'b01, 2'b10);
        add_op(2'b01, 2'b00);
        mul_op("seq_mul1", 2'b10, 2'b00, 0);
        add_op(2'b01, 2'b00);
        mul_op("seq_mul2", 2'b10, 2'b00, 0);
        store_s("seq_result");
        checkOutput("seq_model", s_m, 34);
        checkOutput("seq_valid_pre", valid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("seq_valid", valid, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("seq_valid_drop", valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
